// File: rtl/cordiccart2pol_vector_iter_if.sv
// ----------------------------------------------------------------------------
// cordiccart2pol_vector_iter_if
//
// Purpose:
//   Bundles the ap_* handshake, the Cartesian input sample and the polar
//   results of the iterative CORDIC vectoring engine into one interface.
//
// Handshake (ap_ctrl_hs style):
//   The requester raises ap_start with x_in/y_in valid. The engine accepts
//   only while ap_idle is high; in the accepting cycle ap_ready pulses for one
//   cycle and x_in/y_in are captured on that clock edge. ap_start seen while
//   the engine is busy is dropped, never queued. When the result is ready,
//   ap_done pulses for exactly one cycle; mag_o/theta_o are valid in that
//   cycle and are held until the next ap_done. ap_ready and ap_done are never
//   high in the same cycle.
//
// Signals:
//   ap_start   requester -> engine  start request
//   x_in       requester -> engine  signed 8-bit x sample
//   y_in       requester -> engine  signed 8-bit y sample
//   ap_ready   engine -> requester  one-cycle accept pulse
//   ap_done    engine -> requester  one-cycle result-valid pulse
//   ap_idle    engine -> requester  high while the engine is idle
//   mag_o      engine -> requester  signed raw magnitude (always >= 0)
//   gain_o     engine -> requester  unsigned CORDIC gain constant
//   theta_o    engine -> requester  signed phase, LSB = pi/128
//   fsm_state  engine -> requester  debug view of the control FSM
// ----------------------------------------------------------------------------
interface cordiccart2pol_vector_iter_if;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic signed [7:0] x_in;
    logic signed [7:0] y_in;
    logic signed [7:0] mag_o;
    logic        [5:0] gain_o;
    logic signed [7:0] theta_o;
    logic        [1:0] fsm_state;

    // Requester side (testbench / upstream control).
    modport master (
        output ap_start,
        output x_in,
        output y_in,
        input  ap_ready,
        input  ap_done,
        input  ap_idle,
        input  mag_o,
        input  gain_o,
        input  theta_o,
        input  fsm_state
    );

    // Engine side.
    modport slave (
        input  ap_start,
        input  x_in,
        input  y_in,
        output ap_ready,
        output ap_done,
        output ap_idle,
        output mag_o,
        output gain_o,
        output theta_o,
        output fsm_state
    );
endinterface : cordiccart2pol_vector_iter_if

// File: rtl/cordiccart2pol_vector_iter.sv
// ----------------------------------------------------------------------------
// cordiccart2pol_vector_iter
//
// Purpose:
//   Iterative CORDIC vectoring engine. Converts a signed Cartesian sample
//   (x_in, y_in) into a raw (gain-uncompensated) magnitude and a phase angle,
//   performing one micro-rotation per clock. The raw magnitude feeds the
//   8-bit signed operand of the downstream gain-compensation multiplier and
//   the fixed gain constant feeds its 6-bit unsigned operand; the final
//   ">> 4" of the product belongs to the downstream stage.
//
// Parameters:
//   NUM_ITER  number of micro-rotations, 1..6 (arctan table length)
//   GAIN_K    constant driven on gain_o, round(64 / 1.6468) = 39
//
// Ports:
//   ap_clk    clock, all state changes on the rising edge
//   ap_rst    synchronous active-high reset, valid in any state
//   bus       cordiccart2pol_vector_iter_if.slave (handshake, data, debug)
//
// Build option:
//   CORDIC_ANGLE_SAT_EN  when defined, theta_o is the internal angle
//                        saturated to [-128, +127]; otherwise it is the low
//                        8 bits of the internal angle (two's-complement wrap,
//                        so +pi comes out as -pi).
//
// Timing (cycle 0 = cycle ap_start is seen in IDLE):
//   cycle 0            ap_ready = 1, ap_idle = 1, sample captured
//   cycles 1..NUM_ITER ROT, one micro-rotation each
//   cycle NUM_ITER+1   DONE, ap_done = 1, mag_o/theta_o valid
//   cycle NUM_ITER+2   IDLE again, next request may be accepted
// ----------------------------------------------------------------------------
module cordiccart2pol_vector_iter #(
    parameter int unsigned NUM_ITER = 6,
    parameter logic [5:0]  GAIN_K   = 6'd39
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    cordiccart2pol_vector_iter_if.slave    bus
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value of the final micro-rotation.
    localparam logic [2:0] LAST_ITER = 3'(NUM_ITER - 1);

    // Quarter turn in pi/128 units, used by the pre-rotation.
    localparam logic signed [9:0] TH_QUARTER = 10'sd64;

`ifdef CORDIC_ANGLE_SAT_EN
    localparam logic signed [9:0] TH_MAX = 10'sd127;
    localparam logic signed [9:0] TH_MIN = -10'sd128;
`endif

    // ------------------------------------------------------------------
    // Arctan table, atan(2^-i) in pi/128 units.
    // ------------------------------------------------------------------
    function automatic logic signed [9:0] atan_lut(input logic [2:0] idx);
        logic signed [9:0] v;
        case (idx)
            3'd0:    v = 10'sd32;
            3'd1:    v = 10'sd19;
            3'd2:    v = 10'sd10;
            3'd3:    v = 10'sd5;
            3'd4:    v = 10'sd3;
            3'd5:    v = 10'sd1;
            default: v = 10'sd0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        [1:0] state;
    logic        [2:0] iter_cnt;
    logic signed [9:0] x_int;
    logic signed [9:0] y_int;
    logic signed [9:0] th_int;
    logic signed [7:0] mag_r;
    logic signed [7:0] theta_r;

    // ------------------------------------------------------------------
    // Capture path: sign-extend and pre-rotate into the right half plane
    // so that the micro-rotations (which only cover about +/-99 degrees)
    // can converge for every quadrant.
    // ------------------------------------------------------------------
    logic signed [9:0] x_ext;
    logic signed [9:0] y_ext;
    logic signed [9:0] x_pre;
    logic signed [9:0] y_pre;
    logic signed [9:0] th_pre;

    always_comb begin
        x_ext  = {{2{bus.x_in[7]}}, bus.x_in};
        y_ext  = {{2{bus.y_in[7]}}, bus.y_in};
        x_pre  = x_ext;
        y_pre  = y_ext;
        th_pre = '0;
        if (x_ext[9]) begin
            if (!y_ext[9]) begin
                // Second quadrant: rotate by -90 degrees, remember +pi/2.
                x_pre  = y_ext;
                y_pre  = -x_ext;
                th_pre = TH_QUARTER;
            end else begin
                // Third quadrant: rotate by +90 degrees, remember -pi/2.
                x_pre  = -y_ext;
                y_pre  = x_ext;
                th_pre = -TH_QUARTER;
            end
        end
    end

    // ------------------------------------------------------------------
    // One micro-rotation. Both updates use the old x and y; the direction
    // drives y toward zero and accumulates the matching angle.
    // ------------------------------------------------------------------
    logic signed [9:0] x_sh;
    logic signed [9:0] y_sh;
    logic signed [9:0] atan_i;
    logic signed [9:0] x_nxt;
    logic signed [9:0] y_nxt;
    logic signed [9:0] th_nxt;
    logic signed [7:0] theta_nxt;

    always_comb begin
        x_sh   = x_int >>> iter_cnt;
        y_sh   = y_int >>> iter_cnt;
        atan_i = atan_lut(iter_cnt);
        if (!y_int[9]) begin
            x_nxt  = x_int + y_sh;
            y_nxt  = y_int - x_sh;
            th_nxt = th_int + atan_i;
        end else begin
            x_nxt  = x_int - y_sh;
            y_nxt  = y_int + x_sh;
            th_nxt = th_int - atan_i;
        end
    end

    // Output angle formatting.
    always_comb begin
`ifdef CORDIC_ANGLE_SAT_EN
        if (th_nxt > TH_MAX) begin
            theta_nxt = 8'sd127;
        end else if (th_nxt < TH_MIN) begin
            theta_nxt = -8'sd128;
        end else begin
            theta_nxt = th_nxt[7:0];
        end
`else
        // Two's-complement wrap: +pi (128) maps onto -pi (-128).
        theta_nxt = th_nxt[7:0];
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            x_int    <= '0;
            y_int    <= '0;
            th_int   <= '0;
            mag_r    <= '0;
            theta_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        x_int    <= x_pre;
                        y_int    <= y_pre;
                        th_int   <= th_pre;
                        iter_cnt <= '0;
                        state    <= S_ROT;
                    end
                end
                S_ROT: begin
                    x_int  <= x_nxt;
                    y_int  <= y_nxt;
                    th_int <= th_nxt;
                    if (iter_cnt == LAST_ITER) begin
                        // Results are taken straight from the final
                        // rotation so they are valid in the DONE cycle.
                        mag_r    <= x_nxt[9:2];
                        theta_r  <= theta_nxt;
                        iter_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ap_idle   = (state == S_IDLE);
    assign bus.ap_ready  = (state == S_IDLE) && bus.ap_start;
    assign bus.ap_done   = (state == S_DONE);
    assign bus.mag_o     = mag_r;
    assign bus.gain_o    = GAIN_K;
    assign bus.theta_o   = theta_r;
    assign bus.fsm_state = state;

    // ------------------------------------------------------------------
    // Embedded properties
    // ------------------------------------------------------------------
    a_ready_done_excl: assert property (@(posedge ap_clk)
        !(bus.ap_ready && bus.ap_done));

    a_done_one_cycle: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (state == S_DONE) |=> (state == S_IDLE));

    a_mag_nonneg: assert property (@(posedge ap_clk)
        !mag_r[7]);

    a_state_legal: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (state != 2'd3));

endmodule : cordiccart2pol_vector_iter

// File: tb/tb_cordiccart2pol_vector_iter.sv
// ----------------------------------------------------------------------------
// tb_cordiccart2pol_vector_iter
//
// Directed testbench for the iterative CORDIC vectoring engine. Each scenario
// task drives its own stimulus and checks its own results against
// hand-computed values; the summary line reports totals.
// ----------------------------------------------------------------------------
module tb_cordiccart2pol_vector_iter;

  localparam int MAX_WAIT = 20;

`ifdef CORDIC_ANGLE_SAT_EN
  localparam logic signed [7:0] TH_NEG_X = 8'sd127;
`else
  localparam logic signed [7:0] TH_NEG_X = -8'sd128;
`endif

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic ap_clk;
  logic ap_rst;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  cordiccart2pol_vector_iter_if bus ();

  cordiccart2pol_vector_iter dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int checks;
  int errors;

  // Scoreboard for the back-to-back run: {mag, theta} and due cycle.
  logic [15:0] exp_q[$];
  int          due_q[$];

  // --------------------------------------------------------------------
  // Driver: start one sample in the current cycle (cycle 0) and observe
  // MAX_WAIT further cycles. Optionally pulse ap_start in busy_cyc and
  // ap_rst in rst_cyc. Caller must be just after a rising edge.
  // --------------------------------------------------------------------
  task automatic do_run(
    input  logic signed [7:0] x,
    input  logic signed [7:0] y,
    input  int                busy_cyc,
    input  int                rst_cyc,
    output logic              ready0,
    output logic              idle0,
    output int                done_cyc,
    output int                done_cnt,
    output int                extra_ready,
    output logic signed [7:0] mag_at_done,
    output logic signed [7:0] th_at_done,
    output logic              idle_after_rst
  );
    bus.x_in     = x;
    bus.y_in     = y;
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    ready0         = bus.ap_ready;
    idle0          = bus.ap_idle;
    done_cyc       = -1;
    done_cnt       = 0;
    extra_ready    = 0;
    mag_at_done    = '0;
    th_at_done     = '0;
    idle_after_rst = 1'b0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      @(posedge ap_clk);
      #1;
      bus.ap_start = (c == busy_cyc);
      ap_rst       = (c == rst_cyc);
      // Scramble the inputs so a late capture would be visible.
      bus.x_in     = 8'($urandom_range(0, 255));
      bus.y_in     = 8'($urandom_range(0, 255));
      @(negedge ap_clk);
      if (bus.ap_ready) extra_ready++;
      if (bus.ap_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          mag_at_done = bus.mag_o;
          th_at_done  = bus.theta_o;
        end
      end
      if (c == rst_cyc + 1) idle_after_rst = bus.ap_idle;
    end
    @(posedge ap_clk);
    #1;
    ap_rst       = 1'b0;
    bus.ap_start = 1'b0;
  endtask

  // --------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------
  task automatic test_reset();
    int idle_low;
    int done_seen;
    int ready_seen;
    ap_rst       = 1'b1;
    bus.ap_start = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    idle_low   = 0;
    done_seen  = 0;
    ready_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (!bus.ap_idle) idle_low++;
      if (bus.ap_done)  done_seen++;
      if (bus.ap_ready) ready_seen++;
      @(posedge ap_clk);
      #1;
    end
    checks++;
    if (idle_low !== 0) begin
      errors++;
      $display("FAIL reset idle: cycles with ap_idle low %0d expected 0", idle_low);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset done: ap_done pulses %0d expected 0", done_seen);
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL reset ready: ap_ready pulses %0d expected 0", ready_seen);
    end
    checks++;
    if (bus.mag_o !== 8'sd0) begin
      errors++;
      $display("FAIL reset mag: got %0d expected 0", bus.mag_o);
    end
    checks++;
    if (bus.theta_o !== 8'sd0) begin
      errors++;
      $display("FAIL reset theta: got %0d expected 0", bus.theta_o);
    end
    checks++;
    if (bus.gain_o !== 6'd39) begin
      errors++;
      $display("FAIL reset gain: got %0d expected 39", bus.gain_o);
    end
  endtask

  // Single sample, full timing and value checks.
  task automatic test_vector(
    input string             name,
    input logic signed [7:0] x,
    input logic signed [7:0] y,
    input logic signed [7:0] exp_mag,
    input logic signed [7:0] exp_th
  );
    logic ready0, idle0, idle_ar;
    int done_cyc, done_cnt, extra_ready;
    logic signed [7:0] mag, th;
    do_run(x, y, -1, -1, ready0, idle0, done_cyc, done_cnt, extra_ready,
           mag, th, idle_ar);
    checks++;
    if (ready0 !== 1'b1 || idle0 !== 1'b1) begin
      errors++;
      $display("FAIL %s cycle0: ready=%b idle=%b expected 1 1", name, ready0, idle0);
    end
    checks++;
    if (done_cyc !== 7 || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done: cycle %0d count %0d expected cycle 7 count 1",
               name, done_cyc, done_cnt);
    end
    checks++;
    if (mag !== exp_mag) begin
      errors++;
      $display("FAIL %s mag: got %0d expected %0d", name, mag, exp_mag);
    end
    checks++;
    if (th !== exp_th) begin
      errors++;
      $display("FAIL %s theta: got %0d expected %0d", name, th, exp_th);
    end
    checks++;
    if (bus.mag_o !== exp_mag || bus.theta_o !== exp_th) begin
      errors++;
      $display("FAIL %s hold: got mag %0d theta %0d expected %0d %0d",
               name, bus.mag_o, bus.theta_o, exp_mag, exp_th);
    end
  endtask

  task automatic test_busy_start();
    logic ready0, idle0, idle_ar;
    int done_cyc, done_cnt, extra_ready;
    logic signed [7:0] mag, th;
    do_run(8'sd64, 8'sd0, 3, -1, ready0, idle0, done_cyc, done_cnt,
           extra_ready, mag, th, idle_ar);
    checks++;
    if (extra_ready !== 0) begin
      errors++;
      $display("FAIL busy ready: extra ap_ready %0d expected 0", extra_ready);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 7) begin
      errors++;
      $display("FAIL busy done: count %0d cycle %0d expected 1 at 7", done_cnt, done_cyc);
    end
    checks++;
    if (mag !== 8'sd26 || th !== 8'sd0) begin
      errors++;
      $display("FAIL busy value: got mag %0d theta %0d expected 26 0", mag, th);
    end
  endtask

  task automatic test_mid_reset();
    logic ready0, idle0, idle_ar;
    int done_cyc, done_cnt, extra_ready;
    logic signed [7:0] mag, th;
    do_run(-8'sd128, 8'sd0, -1, 4, ready0, idle0, done_cyc, done_cnt,
           extra_ready, mag, th, idle_ar);
    checks++;
    if (ready0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid accept: ap_ready %b expected 1", ready0);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL rst_mid done: ap_done pulses %0d expected 0", done_cnt);
    end
    checks++;
    if (idle_ar !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid idle: ap_idle %b expected 1", idle_ar);
    end
    checks++;
    if (bus.mag_o !== 8'sd0 || bus.theta_o !== 8'sd0) begin
      errors++;
      $display("FAIL rst_mid clear: got mag %0d theta %0d expected 0 0",
               bus.mag_o, bus.theta_o);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] vx [4];
    logic signed [7:0] vy [4];
    logic signed [7:0] em [4];
    logic signed [7:0] et [4];
    int accepted;
    int overlap;
    int unstable;
    logic        have_last;
    logic [15:0] last;
    logic [15:0] exp_v;
    int          due;
    vx[0] = 8'sd64;   vy[0] = 8'sd0;   em[0] = 8'sd26; et[0] = 8'sd0;
    vx[1] = 8'sd0;    vy[1] = 8'sd64;  em[1] = 8'sd26; et[1] = 8'sd64;
    vx[2] = -8'sd128; vy[2] = 8'sd0;   em[2] = 8'sd52; et[2] = TH_NEG_X;
    vx[3] = -8'sd64;  vy[3] = -8'sd64; em[3] = 8'sd37; et[3] = -8'sd96;
    accepted  = 0;
    overlap   = 0;
    unstable  = 0;
    have_last = 1'b0;
    last      = '0;
    exp_q.delete();
    due_q.delete();
    for (int c = 0; c < 40; c++) begin
      bus.ap_start = (c < 30);
      bus.x_in     = vx[accepted % 4];
      bus.y_in     = vy[accepted % 4];
      @(negedge ap_clk);
      if (bus.ap_ready && bus.ap_done) overlap++;
      if (bus.ap_ready) begin
        checks++;
        if (c !== 8 * accepted) begin
          errors++;
          $display("FAIL b2b ready: accept %0d at cycle %0d expected %0d",
                   accepted, c, 8 * accepted);
        end
        exp_q.push_back({em[accepted % 4], et[accepted % 4]});
        due_q.push_back(c + 7);
        accepted++;
      end
      if (bus.ap_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b spurious: ap_done at cycle %0d with nothing pending", c);
        end else begin
          exp_v = exp_q.pop_front();
          due   = due_q.pop_front();
          if (c !== due || {bus.mag_o, bus.theta_o} !== exp_v) begin
            errors++;
            $display("FAIL b2b done: cycle %0d mag %0d theta %0d expected cycle %0d mag %0d theta %0d",
                     c, bus.mag_o, bus.theta_o, due, $signed(exp_v[15:8]), $signed(exp_v[7:0]));
          end
        end
        last      = {bus.mag_o, bus.theta_o};
        have_last = 1'b1;
      end else if (have_last && {bus.mag_o, bus.theta_o} !== last) begin
        unstable++;
      end
      @(posedge ap_clk);
      #1;
    end
    bus.ap_start = 1'b0;
    checks++;
    if (accepted !== 4) begin
      errors++;
      $display("FAIL b2b accepts: got %0d expected 4", accepted);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b pending: %0d results never done, expected 0", exp_q.size());
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL b2b overlap: ready and done together %0d times expected 0", overlap);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL b2b stable: outputs changed between done pulses %0d times expected 0", unstable);
    end
  endtask

  // --------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------
  initial begin
    checks       = 0;
    errors       = 0;
    ap_rst       = 1'b1;
    bus.ap_start = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    test_reset();
    test_vector("pos_x", 8'sd64, 8'sd0, 8'sd26, 8'sd0);
    test_vector("pos_y", 8'sd0, 8'sd64, 8'sd26, 8'sd64);
    test_vector("neg_x", -8'sd128, 8'sd0, 8'sd52, TH_NEG_X);
    test_vector("third_quad", -8'sd64, -8'sd64, 8'sd37, -8'sd96);
    test_busy_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_cordiccart2pol_vector_iter
